// File: rtl/uart_pkg.sv
// Shared UART types, default timing constants and helpers.
// Used by both the transmit engine and the reusable FIFO consumers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEF_SYSCLK_RATE = 4;
    localparam int DEF_BAUD_RATE   = 1;
    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_STOP_BITS   = 2;

    localparam int CLKS_PER_BIT = DEF_SYSCLK_RATE / DEF_BAUD_RATE;
    localparam int FRAME_BITS   = DEF_DATA_BITS + 2 + DEF_STOP_BITS;

    function automatic int clks_per_bit(input int sysclk_rate, input int baud_rate);
        return sysclk_rate / baud_rate;
    endfunction

    // Payloads up to 32 bits are zero-extended by the caller; zeros do not change parity.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host-side bus of the UART transmitter: write port, CTS, serial line and FIFO status.
// master = host/bench side, slave = transmit engine.
interface uart_tx_engine_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 Wr_En;
    logic [DATA_BITS-1:0] Wr_Data;
    logic                 CTS;
    logic                 Tx;
    logic                 Tx_Busy;
    logic                 FIFO_Full;
    logic                 FIFO_Empty;
    logic [CNT_W-1:0]     Count;
    logic                 Overflow;

    modport master (
        output Wr_En, Wr_Data, CTS,
        input  Tx, Tx_Busy, FIFO_Full, FIFO_Empty, Count, Overflow
    );

    modport slave (
        input  Wr_En, Wr_Data, CTS,
        output Tx, Tx_Busy, FIFO_Full, FIFO_Empty, Count, Overflow
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and a 1-cycle overflow pulse.
// Head word is visible on rd_dat with zero latency; writes while full are dropped.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_n;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign count_n = count + CW'(push) - CW'(pop);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_n;
            full     <= (count_n == CW'(DEPTH));
            empty    <= (count_n == '0);
            overflow <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// FIFO-buffered UART transmitter: start, MSB-first data, even parity, STOP_BITS stop bits.
// First start bit one cycle after the push; CTS is sampled only between frames.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 4,
    parameter int BAUD_RATE   = 1,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             SysClk,
    input  logic             Rst,
    uart_tx_engine_if.slave  bus
);
    localparam int CPB    = clks_per_bit(SYSCLK_RATE, BAUD_RATE);
    localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_N  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W  = (BIT_N > 1) ? $clog2(BIT_N) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t             state_q, state_n;
    logic [BAUD_W-1:0]     baud_q, baud_n;
    logic [BIT_W-1:0]      bit_q, bit_n;
    logic [DATA_BITS-1:0]  sh_q, sh_n;
    logic                  par_q, par_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;
    logic                  pop;
    logic                  baud_end;

    logic [DATA_BITS-1:0]  fifo_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_ovf;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk      (SysClk),
        .rst      (Rst),
        .wr_en    (bus.Wr_En),
        .wr_dat   (bus.Wr_Data),
        .rd_en    (pop),
        .rd_dat   (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    assign bus.Tx         = tx_q;
    assign bus.Tx_Busy    = busy_q;
    assign bus.FIFO_Full  = fifo_full;
    assign bus.FIFO_Empty = fifo_empty;
    assign bus.Count      = fifo_count;
    assign bus.Overflow   = fifo_ovf;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            sh_q    <= sh_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
        end
    end

    // Tx is registered: each branch loads the level of the bit that starts on this edge.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        sh_n    = sh_q;
        par_n   = par_q;
        tx_n    = tx_q;
        busy_n  = busy_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_n   = 1'b1;
                baud_n = '0;
                bit_n  = '0;
                if (!fifo_empty && bus.CTS) begin
                    pop     = 1'b1;
                    sh_n    = fifo_dat;
                    par_n   = even_parity(32'(fifo_dat));
                    busy_n  = 1'b1;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    tx_n    = sh_q[DATA_BITS-1];
                    state_n = DATA;
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_n   = '0;
                        tx_n    = par_q;
                        state_n = PARITY;
                    end else begin
                        bit_n = bit_q + 1'b1;
                        sh_n  = sh_q << 1;
                        tx_n  = sh_q[DATA_BITS-2];
                    end
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
            PARITY: begin
                if (baud_end) begin
                    baud_n  = '0;
                    tx_n    = 1'b1;
                    state_n = STOP;
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_n   = '0;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end else begin
                    baud_n = baud_q + 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed scenarios plus random traffic, every cycle checked
// against a timestamp-based frame model.
module tb_uart_tx_engine;
    localparam int CPB       = 4;
    localparam int DATA_BITS = 8;
    localparam int NBITS     = DATA_BITS + 2 + 2;
    localparam int FRAME_CYC = NBITS * CPB;
    localparam int DEPTH     = 8;

    logic SysClk = 1'b0;
    logic Rst;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_engine_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_engine #(
        .SYSCLK_RATE (4),
        .BAUD_RATE   (1),
        .DATA_BITS   (DATA_BITS),
        .STOP_BITS   (2),
        .FIFO_DEPTH  (DEPTH)
    ) u_dut (
        .SysClk (SysClk),
        .Rst    (Rst),
        .bus    (bus)
    );

    always #5 SysClk = ~SysClk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a frame is a list of line levels, one per bit period.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DATA_BITS) return d[DATA_BITS - idx];
        if (idx == DATA_BITS + 1) return ^d;
        return 1'b1;
    endfunction

    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_age = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;

    always @(posedge SysClk) begin
        int size_b;
        if (Rst) begin
            mq.delete();
            m_active = 1'b0;
            m_age    = 0;
            m_ovf    = 1'b0;
        end else begin
            size_b = mq.size();
            if (m_active) begin
                m_age++;
                if (m_age == FRAME_CYC) m_active = 1'b0;
            end else if (size_b > 0 && bus.CTS) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_age    = 0;
            end
            m_ovf = 1'b0;
            if (bus.Wr_En) begin
                if (size_b < DEPTH) mq.push_back(bus.Wr_Data);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge SysClk) begin
        if (chk_en) begin
            check_eq("tx",    32'(bus.Tx), m_active ? 32'(frame_bit(m_cur, m_age / CPB)) : 32'd1);
            check_eq("busy",  32'(bus.Tx_Busy), 32'(m_active));
            check_eq("count", 32'(bus.Count), 32'(mq.size()));
            check_eq("full",  32'(bus.FIFO_Full), 32'(mq.size() == DEPTH));
            check_eq("empty", 32'(bus.FIFO_Empty), 32'(mq.size() == 0));
            check_eq("ovf",   32'(bus.Overflow), 32'(m_ovf));
        end
    end

    task automatic wr(input logic [7:0] d);
        bus.Wr_Data = d;
        bus.Wr_En   = 1'b1;
        @(negedge SysClk);
        bus.Wr_En   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge SysClk);
    endtask

    initial begin
        int busy_cnt;
        Rst         = 1'b1;
        bus.Wr_En   = 1'b0;
        bus.Wr_Data = '0;
        bus.CTS     = 1'b0;
        idle(3);
        chk_en = 1'b1;
        check_eq("rst_tx",    32'(bus.Tx), 32'd1);
        check_eq("rst_busy",  32'(bus.Tx_Busy), 32'd0);
        check_eq("rst_empty", 32'(bus.FIFO_Empty), 32'd1);
        check_eq("rst_full",  32'(bus.FIFO_Full), 32'd0);
        check_eq("rst_count", 32'(bus.Count), 32'd0);
        check_eq("rst_ovf",   32'(bus.Overflow), 32'd0);
        Rst = 1'b0;
        idle(2);

        // Single frame 0xAB: start bit begins one edge after the push edge.
        bus.CTS = 1'b1;
        wr(8'hAB);
        check_eq("ab_tx_e0", 32'(bus.Tx), 32'd1);
        idle(1);
        check_eq("ab_tx_e1", 32'(bus.Tx), 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.Tx_Busy) busy_cnt++;
            idle(1);
        end
        check_eq("ab_busy_len", busy_cnt, 32'd48);

        // Held by CTS, then released: three frames back to back.
        bus.CTS = 1'b0;
        wr(8'h00);
        wr(8'hFF);
        wr(8'h81);
        idle(5);
        check_eq("hold_count", 32'(bus.Count), 32'd3);
        check_eq("hold_tx",    32'(bus.Tx), 32'd1);
        bus.CTS = 1'b1;
        idle(3 * (FRAME_CYC + 1) + 10);

        // Fill, overflow, drain.
        bus.CTS = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'(i));
        check_eq("fill_full",  32'(bus.FIFO_Full), 32'd1);
        check_eq("fill_count", 32'(bus.Count), 32'd8);
        wr(8'h55);
        check_eq("ovf_pulse", 32'(bus.Overflow), 32'd1);
        idle(1);
        check_eq("ovf_clear", 32'(bus.Overflow), 32'd0);
        check_eq("ovf_count", 32'(bus.Count), 32'd8);
        bus.CTS = 1'b1;
        idle(8 * (FRAME_CYC + 1) + 10);

        // CTS dropped mid-frame: current frame completes, next one waits.
        wr(8'h3C);
        wr(8'hC3);
        idle(10);
        bus.CTS = 1'b0;
        idle(60);
        check_eq("cts_hold_busy",  32'(bus.Tx_Busy), 32'd0);
        check_eq("cts_hold_count", 32'(bus.Count), 32'd1);
        bus.CTS = 1'b1;
        idle(60);

        // Reset during the parity bit.
        wr(8'hA5);
        idle(37);
        Rst = 1'b1;
        idle(1);
        Rst = 1'b0;
        check_eq("mid_rst_tx",    32'(bus.Tx), 32'd1);
        check_eq("mid_rst_busy",  32'(bus.Tx_Busy), 32'd0);
        check_eq("mid_rst_empty", 32'(bus.FIFO_Empty), 32'd1);
        check_eq("mid_rst_count", 32'(bus.Count), 32'd0);
        wr(8'h5A);
        idle(60);

        // Push on the same edge that pops the next frame.
        wr(8'h12);
        wr(8'h34);
        idle(48);
        wr(8'h56);
        check_eq("pushpop_count", 32'(bus.Count), 32'd1);
        check_eq("pushpop_ovf",   32'(bus.Overflow), 32'd0);
        idle(2 * (FRAME_CYC + 1) + 10);

        // Random traffic with CTS toggling and rare resets.
        for (int c = 0; c < 2500; c++) begin
            if (c % 50 == 0) bus.CTS = ($urandom_range(0, 3) != 0);
            bus.Wr_En   = ($urandom_range(0, 99) < 6);
            bus.Wr_Data = 8'($urandom);
            Rst         = ($urandom_range(0, 1499) == 0);
            idle(1);
        end
        bus.Wr_En = 1'b0;
        Rst       = 1'b0;
        bus.CTS   = 1'b1;
        idle(DEPTH * (FRAME_CYC + 1) + 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
